// File: rtl/agent_motion_ctrl.sv
// Tile-map movement and collision controller for a single maze agent.
// Each accepted tick probes the leading-edge tile of the next pixel step and
// commits the step unless the tile is a wall. A buffered turn request is
// applied once the agent is aligned for it, or at once for a reversal. On
// landing squarely on a tile holding a pellet, the tile is cleared through a
// one-cycle map write, and a power pellet restarts the power timer.
//
// Map read handshake: map_rd_req rises with map_tx/map_ty valid and holds
// both stable until the first cycle with map_rd_ack high; map_rd_data is
// taken in that same cycle and map_rd_req drops on the following edge.
// A read is never outstanding while map_wr_en is high.
module agent_motion_ctrl #(
    parameter int COORD_W     = 8,
    parameter int MAP_AW      = 5,
    parameter int TILE_SIZE   = 5,
    parameter int X_MAX       = 155,
    parameter int Y_MAX       = 115,
    parameter int DIR_INIT    = 1,
    parameter int WALL_CODE   = 3,
    parameter int PELLET_CODE = 2,
    parameter int POWER_CODE  = 1,
    parameter int EMPTY_CODE  = 0,
    parameter int POWER_TICKS = 250
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               tick,
    input  logic [1:0]         dir_req,
    input  logic               dir_req_valid,
    input  logic [COORD_W-1:0] x_init,
    input  logic [COORD_W-1:0] y_init,
    output logic               map_rd_req,
    input  logic               map_rd_ack,
    input  logic [2:0]         map_rd_data,
    output logic               map_wr_en,
    output logic [2:0]         map_wr_data,
    output logic [MAP_AW-1:0]  map_tx,
    output logic [MAP_AW-1:0]  map_ty,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [1:0]         dir,
    output logic               moving,
    output logic               powered,
    output logic               pellet_eaten,
    output logic               power_eaten,
    output logic               tick_overrun,
    output logic               busy
);

    localparam int CNT_W = $clog2(POWER_TICKS + 1);

    localparam logic [COORD_W-1:0] TILE_C   = COORD_W'(TILE_SIZE);
    localparam logic [COORD_W-1:0] XMAX_C   = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] YMAX_C   = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] ONE_C    = COORD_W'(1);
    localparam logic [COORD_W:0]   TILE_W1  = (COORD_W+1)'(TILE_SIZE);
    localparam logic [COORD_W:0]   EDGE_W1  = (COORD_W+1)'(TILE_SIZE - 1);
    localparam logic [1:0]         DIR_INIT_C = 2'(DIR_INIT);
    localparam logic [2:0]         WALL_C   = 3'(WALL_CODE);
    localparam logic [2:0]         PELLET_C = 3'(PELLET_CODE);
    localparam logic [2:0]         POWER_C  = 3'(POWER_CODE);
    localparam logic [2:0]         EMPTY_C  = 3'(EMPTY_CODE);
    localparam logic [CNT_W-1:0]   TICKS_C  = CNT_W'(POWER_TICKS);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_RD_TGT,
        S_CHECK,
        S_RD_CUR,
        S_EAT
    } state_t;

    state_t             state;
    logic               pend_valid;
    logic [1:0]         pend_dir;
    logic               retry;
    logic [1:0]         cd;
    logic               cd_pend;
    logic [COORD_W-1:0] tgt_x;
    logic [COORD_W-1:0] tgt_y;
    logic [2:0]         tgt_code;
    logic [CNT_W-1:0]   power_cnt;

    logic               aligned_turn;
    logic               use_pend;
    logic [1:0]         calc_dir;
    logic [COORD_W-1:0] calc_x;
    logic [COORD_W-1:0] calc_y;
    logic [MAP_AW-1:0]  probe_tx;
    logic [MAP_AW-1:0]  probe_ty;

    assign map_wr_data = EMPTY_C;
    assign busy        = (state != S_IDLE);

    // Candidate direction, wrapped one-pixel target and leading-edge probe tile.
    always_comb begin
        aligned_turn = pend_dir[0] ? ((y % TILE_C) == '0) : ((x % TILE_C) == '0);
        use_pend     = pend_valid && !retry &&
                       ((pend_dir == (dir ^ 2'b10)) || aligned_turn);
        calc_dir     = use_pend ? pend_dir : dir;
        calc_x       = x;
        calc_y       = y;
        probe_tx     = MAP_AW'(x / TILE_C);
        probe_ty     = MAP_AW'(y / TILE_C);
        case (calc_dir)
            2'd0: begin
                calc_y   = (y == '0) ? YMAX_C : (y - ONE_C);
                probe_ty = MAP_AW'(calc_y / TILE_C);
            end
            2'd1: begin
                calc_x   = (x == XMAX_C) ? '0 : (x + ONE_C);
                probe_tx = MAP_AW'(({1'b0, calc_x} + EDGE_W1) / TILE_W1);
            end
            2'd2: begin
                calc_y   = (y == YMAX_C) ? '0 : (y + ONE_C);
                probe_ty = MAP_AW'(({1'b0, calc_y} + EDGE_W1) / TILE_W1);
            end
            default: begin
                calc_x   = (x == '0) ? XMAX_C : (x - ONE_C);
                probe_tx = MAP_AW'(calc_x / TILE_C);
            end
        endcase
    end

    // Movement FSM, map handshakes, pending turn register and power timer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            x            <= x_init;
            y            <= y_init;
            dir          <= DIR_INIT_C;
            moving       <= 1'b1;
            powered      <= 1'b0;
            power_cnt    <= '0;
            pend_valid   <= 1'b0;
            pend_dir     <= '0;
            retry        <= 1'b0;
            cd           <= DIR_INIT_C;
            cd_pend      <= 1'b0;
            tgt_x        <= '0;
            tgt_y        <= '0;
            tgt_code     <= '0;
            map_rd_req   <= 1'b0;
            map_wr_en    <= 1'b0;
            map_tx       <= '0;
            map_ty       <= '0;
            pellet_eaten <= 1'b0;
            power_eaten  <= 1'b0;
            tick_overrun <= 1'b0;
        end else begin
            pellet_eaten <= 1'b0;
            power_eaten  <= 1'b0;
            map_wr_en    <= 1'b0;
            tick_overrun <= tick && (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (tick && enable) begin
                        state <= S_CALC;
                        retry <= 1'b0;
                        if (power_cnt != '0) begin
                            power_cnt <= power_cnt - CNT_ONE;
                            powered   <= (power_cnt != CNT_ONE);
                        end
                    end
                end
                S_CALC: begin
                    cd         <= calc_dir;
                    cd_pend    <= use_pend;
                    tgt_x      <= calc_x;
                    tgt_y      <= calc_y;
                    map_tx     <= probe_tx;
                    map_ty     <= probe_ty;
                    map_rd_req <= 1'b1;
                    state      <= S_RD_TGT;
                end
                S_RD_TGT: begin
                    if (map_rd_ack) begin
                        tgt_code   <= map_rd_data;
                        map_rd_req <= 1'b0;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (tgt_code != WALL_C) begin
                        x      <= tgt_x;
                        y      <= tgt_y;
                        dir    <= cd;
                        moving <= 1'b1;
                        if (cd_pend) pend_valid <= 1'b0;
                        if (((tgt_x % TILE_C) == '0) && ((tgt_y % TILE_C) == '0)) begin
                            map_tx     <= MAP_AW'(tgt_x / TILE_C);
                            map_ty     <= MAP_AW'(tgt_y / TILE_C);
                            map_rd_req <= 1'b1;
                            state      <= S_RD_CUR;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (cd_pend && (cd != dir)) begin
                        // Blocked turn: probe straight ahead once, keep the request.
                        retry <= 1'b1;
                        state <= S_CALC;
                    end else begin
                        moving <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                S_RD_CUR: begin
                    if (map_rd_ack) begin
                        map_rd_req <= 1'b0;
                        if (map_rd_data == PELLET_C) begin
                            map_wr_en    <= 1'b1;
                            pellet_eaten <= 1'b1;
                            state        <= S_EAT;
                        end else if (map_rd_data == POWER_C) begin
                            map_wr_en   <= 1'b1;
                            power_eaten <= 1'b1;
                            power_cnt   <= TICKS_C;
                            powered     <= 1'b1;
                            state       <= S_EAT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_EAT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // The newest request always wins, even over a same-cycle clear.
            if (dir_req_valid) begin
                pend_valid <= 1'b1;
                pend_dir   <= dir_req;
            end
        end
    end

endmodule

// File: tb/tb_agent_motion_ctrl.sv
// Directed bench for agent_motion_ctrl: a map responder that acks one cycle
// after each request, monitors for writes and pulses, and a linear sequence
// of hand-computed checks.
module tb_agent_motion_ctrl;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       tick;
    logic [1:0] dir_req;
    logic       dir_req_valid;
    logic [7:0] x_init;
    logic [7:0] y_init;
    logic       map_rd_req;
    logic       map_rd_ack;
    logic [2:0] map_rd_data;
    logic       map_wr_en;
    logic [2:0] map_wr_data;
    logic [4:0] map_tx;
    logic [4:0] map_ty;
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] dir;
    logic       moving;
    logic       powered;
    logic       pellet_eaten;
    logic       power_eaten;
    logic       tick_overrun;
    logic       busy;

    logic [2:0] map_mem [0:31][0:31];
    logic       hold_ack;
    logic       seen;
    int         last_tx, last_ty;
    int         wr_cnt, wr_tx, wr_ty, wr_data;
    int         pel_cnt, pow_cnt, ovr_cnt, overlap_cnt;
    int         n_checks, n_pass, n_fail;
    int         b_wr, b_pel, b_pow, b_ovr;

    agent_motion_ctrl dut (
        .clock(clock), .reset(reset), .enable(enable), .tick(tick),
        .dir_req(dir_req), .dir_req_valid(dir_req_valid),
        .x_init(x_init), .y_init(y_init),
        .map_rd_req(map_rd_req), .map_rd_ack(map_rd_ack), .map_rd_data(map_rd_data),
        .map_wr_en(map_wr_en), .map_wr_data(map_wr_data),
        .map_tx(map_tx), .map_ty(map_ty),
        .x(x), .y(y), .dir(dir), .moving(moving), .powered(powered),
        .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
        .tick_overrun(tick_overrun), .busy(busy)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Map responder and monitors, all acting on the falling edge.
    initial begin
        map_rd_ack = 1'b0; map_rd_data = '0; seen = 1'b0;
        last_tx = -1; last_ty = -1;
        wr_cnt = 0; wr_tx = -1; wr_ty = -1; wr_data = -1;
        pel_cnt = 0; pow_cnt = 0; ovr_cnt = 0; overlap_cnt = 0;
        forever begin
            @(negedge clock);
            if (map_rd_req && !map_rd_ack && !hold_ack) begin
                if (seen) begin
                    map_rd_ack  = 1'b1;
                    map_rd_data = map_mem[map_ty][map_tx];
                    last_tx     = int'(map_tx);
                    last_ty     = int'(map_ty);
                    seen        = 1'b0;
                end else begin
                    seen = 1'b1;
                end
            end else begin
                map_rd_ack = 1'b0;
                if (!map_rd_req) seen = 1'b0;
            end
            if (map_wr_en) begin
                wr_cnt++;
                wr_tx   = int'(map_tx);
                wr_ty   = int'(map_ty);
                wr_data = int'(map_wr_data);
            end
            if (map_wr_en && map_rd_req) overlap_cnt++;
            if (pellet_eaten) pel_cnt++;
            if (power_eaten) pow_cnt++;
            if (tick_overrun) ovr_cnt++;
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_map(input logic [2:0] code);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                map_mem[r][c] = code;
    endtask

    task automatic do_reset(input logic [7:0] xi, input logic [7:0] yi);
        @(negedge clock);
        reset = 1'b1; x_init = xi; y_init = yi;
        tick = 1'b0; dir_req_valid = 1'b0; enable = 1'b1; hold_ack = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clock);
            k++;
        end
        check("idle_reached", busy, 0);
    endtask

    task automatic tick_once();
        @(negedge clock); tick = 1'b1;
        @(negedge clock); tick = 1'b0;
        wait_idle();
    endtask

    task automatic request_dir(input logic [1:0] d);
        @(negedge clock); dir_req = d; dir_req_valid = 1'b1;
        @(negedge clock); dir_req_valid = 1'b0;
    endtask

    task automatic snap();
        b_wr = wr_cnt; b_pel = pel_cnt; b_pow = pow_cnt; b_ovr = ovr_cnt;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; n_fail = 0;
        reset = 1'b1; enable = 1'b1; tick = 1'b0; dir_req = '0; dir_req_valid = 1'b0;
        x_init = 8'd10; y_init = 8'd10; hold_ack = 1'b0;
        fill_map(3'd0);

        // Reset state
        do_reset(8'd10, 8'd10);
        check("rst_x", x, 10);
        check("rst_y", y, 10);
        check("rst_dir", dir, 1);
        check("rst_moving", moving, 1);
        check("rst_powered", powered, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_req", map_rd_req, 0);
        check("rst_wr_en", map_wr_en, 0);

        // Move right on an open map: target x=11, probe ((11+4)/5, 10/5) = (3,2)
        snap();
        @(negedge clock); tick = 1'b1;
        @(negedge clock); tick = 1'b0;
        repeat (3) @(negedge clock);
        check("move_x_before", x, 10);
        @(negedge clock);
        check("move_x_after5", x, 11);
        check("move_moving", moving, 1);
        check("move_probe_tx", last_tx, 3);
        check("move_probe_ty", last_ty, 2);
        wait_idle();
        check("move_no_write", wr_cnt - b_wr, 0);

        // Wall everywhere: no move
        do_reset(8'd10, 8'd10);
        fill_map(3'd3);
        snap();
        tick_once();
        check("wall_x", x, 10);
        check("wall_moving", moving, 0);
        check("wall_dir", dir, 1);
        check("wall_no_write", wr_cnt - b_wr, 0);

        // Queued turn up, applied at x=15 with probe (3,1)
        do_reset(8'd12, 8'd10);
        fill_map(3'd0);
        request_dir(2'd0);
        repeat (3) tick_once();
        check("turn_x15", x, 15);
        check("turn_dir_still_right", dir, 1);
        tick_once();
        check("turn_y", y, 9);
        check("turn_x", x, 15);
        check("turn_dir", dir, 0);
        check("turn_probe_tx", last_tx, 3);
        check("turn_probe_ty", last_ty, 1);

        // Same with (3,1) a wall: fall back to right, request stays pending
        do_reset(8'd12, 8'd10);
        fill_map(3'd0);
        map_mem[1][3] = 3'd3;
        request_dir(2'd0);
        repeat (3) tick_once();
        tick_once();
        check("fb_x", x, 16);
        check("fb_y", y, 10);
        check("fb_dir", dir, 1);
        check("fb_moving", moving, 1);
        repeat (4) tick_once();
        check("fb_x20", x, 20);
        tick_once();
        check("fb_late_turn_y", y, 9);
        check("fb_late_turn_dir", dir, 0);
        check("fb_late_turn_x", x, 20);

        // Eat a normal pellet at (15,10): tile (3,2)
        do_reset(8'd14, 8'd10);
        fill_map(3'd0);
        map_mem[2][3] = 3'd2;
        snap();
        tick_once();
        check("eat_x", x, 15);
        check("eat_wr_count", wr_cnt - b_wr, 1);
        check("eat_wr_tx", wr_tx, 3);
        check("eat_wr_ty", wr_ty, 2);
        check("eat_wr_data", wr_data, 0);
        check("eat_pellet_pulse", pel_cnt - b_pel, 1);
        check("eat_no_power_pulse", pow_cnt - b_pow, 0);
        check("eat_powered", powered, 0);

        // Power pellet: powered for exactly 250 accepted ticks
        do_reset(8'd14, 8'd10);
        fill_map(3'd0);
        map_mem[2][3] = 3'd1;
        snap();
        tick_once();
        check("pow_pulse", pow_cnt - b_pow, 1);
        check("pow_no_pellet_pulse", pel_cnt - b_pel, 0);
        check("pow_powered", powered, 1);
        fill_map(3'd3);
        repeat (249) tick_once();
        check("pow_after_249", powered, 1);
        snap();
        @(negedge clock); enable = 1'b0; tick = 1'b1;
        @(negedge clock); tick = 1'b0; enable = 1'b1;
        @(negedge clock);
        check("dis_tick_busy", busy, 0);
        check("dis_tick_no_ovr", ovr_cnt - b_ovr, 0);
        check("dis_tick_powered", powered, 1);
        tick_once();
        check("pow_after_250", powered, 0);
        tick_once();
        check("pow_stays_off", powered, 0);

        // Wrap left from x=0 and drop a tick that arrives during RD_TGT
        do_reset(8'd0, 8'd10);
        fill_map(3'd0);
        request_dir(2'd3);
        snap();
        @(negedge clock); tick = 1'b1;
        @(negedge clock); tick = 1'b0;
        @(negedge clock); tick = 1'b1;
        @(negedge clock); tick = 1'b0;
        check("ovr_pulse", tick_overrun, 1);
        wait_idle();
        check("wrap_x", x, 155);
        check("wrap_dir", dir, 3);
        check("wrap_probe_tx", last_tx, 31);
        check("ovr_count", ovr_cnt - b_ovr, 1);
        repeat (10) @(negedge clock);
        check("wrap_single_move", x, 155);

        // Reset during an unanswered read
        do_reset(8'd14, 8'd10);
        fill_map(3'd0);
        map_mem[2][3] = 3'd1;
        tick_once();
        check("mid_pre_powered", powered, 1);
        hold_ack = 1'b1;
        @(negedge clock); tick = 1'b1;
        @(negedge clock); tick = 1'b0;
        for (int k = 0; k < 20 && !map_rd_req; k++) @(negedge clock);
        check("mid_rd_req_up", map_rd_req, 1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rd_req_drop", map_rd_req, 0);
        check("mid_x", x, 14);
        check("mid_y", y, 10);
        check("mid_dir", dir, 1);
        check("mid_powered", powered, 0);
        check("mid_busy", busy, 0);
        reset = 1'b0;
        hold_ack = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_no_req_after", map_rd_req, 0);
        check("mid_still_idle", busy, 0);
        tick_once();
        check("mid_recover_x", x, 15);

        check("rd_wr_overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
